dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit words in the data array (power of two, at least 4).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of word 0.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL mean a memory request is presented this cycle.
REQ-006 req_ready  output  1  SHALL mean the controller accepts a request this cycle.
REQ-007 MemWrite, MemRead  input  1 each  SHALL carry the request type from the load/store unit.
REQ-008 addrb  input  32  SHALL carry the byte address; bits [1:0] are ignored.
REQ-009 web  input  4  SHALL carry the per-byte write enables.
REQ-010 dib  input  32  SHALL carry the lane-aligned write data.
REQ-011 DMEM_word  output  32  SHALL carry the full aligned word read, unshifted.
REQ-012 rsp_valid  output  1  SHALL mean a response (read data, write ack or fault) is presented.
REQ-013 rsp_ready  input  1  SHALL mean the consumer takes the response this cycle.
REQ-014 fault  output  1  SHALL mean the current response is for an out-of-range address; qualified by rsp_valid.

Function
REQ-015 The FSM SHALL have states IDLE, RD, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance: req_valid & req_ready & (MemRead | MemWrite); req_valid with neither set SHALL be ignored, FSM stays IDLE.
REQ-017 MemWrite and MemRead both set SHALL be treated as a write.
REQ-018 Word index = (addrb - BASE_ADDR) >> 2; in range iff addrb >= BASE_ADDR and index < DEPTH_WORDS.
REQ-019 Accepted in-range write: at the acceptance edge, each byte lane i with web[i]=1 SHALL take dib[8i+7:8i], other lanes unchanged; FSM -> RESP, fault=0, DMEM_word unchanged.
REQ-020 Write with web=4'b0000 SHALL be acknowledged identically with no array change.
REQ-021 Accepted in-range read: request registered at acceptance edge, FSM -> RD; array read registered at next edge into DMEM_word, FSM -> RESP; rsp_valid first high 2 cycles after acceptance.
REQ-022 Accepted out-of-range request (read or write): no array change, DMEM_word set to 0, fault=1, FSM -> RESP at acceptance edge.
REQ-023 In RESP rsp_valid=1; DMEM_word and fault SHALL hold stable until rsp_ready=1, then FSM -> IDLE on that edge.
REQ-024 Outside RESP rsp_valid=0 and fault=0; DMEM_word SHALL retain its last loaded value.
REQ-025 A read accepted on the cycle after a write to the same word SHALL return post-write data (write committed before read sampled).
REQ-026 Request inputs SHALL be ignored when req_ready=0; no request buffering.
REQ-027 Minimum throughput: write/fault one per 2 cycles, read one per 3 cycles, with rsp_ready held 1.

Reset
REQ-028 rst_n low SHALL immediately force FSM=IDLE, rsp_valid=0, fault=0, DMEM_word=0, without waiting for clk.
REQ-029 Reset mid-operation (RD or RESP) SHALL discard the in-flight response; a write already committed SHALL remain in the array.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 After rst_n rises, req_ready SHALL be 1 on the first clk cycle.

Verification
REQ-032 Write addr 0x10, web=1111, dib=0xDEADBEEF; then read 0x13 -> rsp_valid 2 cycles after read acceptance, DMEM_word=0xDEADBEEF, fault=0.
REQ-033 Write addr 0x20 dib=0x11223344 web=1111, then web=0100 dib=0x00AA0000; read 0x20 -> DMEM_word=0x11AA3344.
REQ-034 Read at BASE_ADDR+4*DEPTH_WORDS (0x1000 default) -> rsp_valid 1 cycle after acceptance, fault=1, DMEM_word=0; write there leaves word 0 unchanged.
REQ-035 Read response with rsp_ready held 0 for 5 cycles -> rsp_valid, DMEM_word stable, req_ready=0 throughout; IDLE one edge after rsp_ready=1.
REQ-036 Assert rst_n=0 mid-clock while in RD -> rsp_valid=0, req_ready=1 immediately and after release; previously written data still readable.
REQ-037 req_valid=1 with MemRead=MemWrite=0 -> no response, req_ready stays 1; both set with web=0001 dib=0x55 at 0x30 -> byte 0 of word 0x30 becomes 0x55.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller: byte-lane writes, registered reads,
// range-checked addressing and a held response handshake.
module dmem_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] addrb,
  input  logic [3:0]  web,
  input  logic [31:0] dib,
  output logic [31:0] DMEM_word,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        fault
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD, RESP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [31:0]   dmem_word_q, dmem_word_d;
  logic          fault_q, fault_d;

  logic [32:0]   off;
  logic          in_range, accept, do_wr;
  logic [AW-1:0] idx;
  logic [NUM_LANES-1:0]       lane_we;
  logic [NUM_LANES-1:0][7:0]  rdata;
  logic          unused_off;

  // Borrow out of the 33-bit subtraction flags addresses below the base.
  assign off        = {1'b0, addrb} - {1'b0, BASE_ADDR};
  assign in_range   = !off[32] && (off[31:AW+2] == '0);
  assign idx        = off[AW+1:2];
  assign unused_off = ^off[1:0];

  assign accept = req_valid && (state_q == IDLE) && (MemRead || MemWrite);
  assign do_wr  = accept && MemWrite && in_range;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_we[g] = do_wr && web[g];
    dmem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[g]),
      .waddr (idx),
      .wdata (dib[8*g +: 8]),
      .raddr (rd_idx_q),
      .rdata (rdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_idx_q    <= '0;
      dmem_word_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      dmem_word_q <= dmem_word_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (MemWrite || !in_range) ? RESP : RD;
      RD:      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writes and faults respond straight from IDLE; reads take one array cycle.
  always_comb begin
    rd_idx_d    = rd_idx_q;
    dmem_word_d = dmem_word_q;
    fault_d     = fault_q;
    if (accept) begin
      rd_idx_d = idx;
      fault_d  = !in_range;
      if (!in_range) dmem_word_d = '0;
    end
    if (state_q == RD) begin
      dmem_word_d = rdata;
      fault_d     = 1'b0;
    end
    if (state_q == RESP && rsp_ready) fault_d = 1'b0;
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    fault     = fault_q && (state_q == RESP);
    DMEM_word = dmem_word_q;
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a transaction-level model predicts every
// cycle's outputs; literal checks pin the model on the key scenarios.
module tb_dmem_ctrl;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk, rst_n, req_valid, req_ready, MemWrite, MemRead;
  logic [31:0] addrb, dib, DMEM_word;
  logic [3:0]  web;
  logic        rsp_valid, rsp_ready, fault;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemWrite(MemWrite), .MemRead(MemRead), .addrb(addrb), .web(web),
    .dib(dib), .DMEM_word(DMEM_word), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // expected outputs for the current cycle
  logic        m_ready = 1'b1, m_valid = 1'b0, m_fault = 1'b0;
  logic [31:0] m_word = '0;
  logic [31:0] mm [int];
  logic        chk_en = 1'b0;

  // latency / first-response observation
  logic        track = 1'b0;
  int          trk_cyc = 0, obs_lat = 0;
  logic [31:0] obs_word = '0;
  logic        obs_fault = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    longint unsigned la = a, lb = BASE;
    return (la >= lb) && (((la - lb) >> 2) < DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
      chk("fault", {31'b0, fault}, {31'b0, m_valid && m_fault});
      chk("DMEM_word", DMEM_word, m_word);
    end
    if (track) begin
      trk_cyc++;
      if (rsp_valid) begin
        obs_lat = trk_cyc; obs_word = DMEM_word; obs_fault = fault; track = 1'b0;
      end else if (trk_cyc > 8) begin
        track = 1'b0; n_chk++; n_err++;
        $display("FAIL rsp_timeout: got no rsp_valid expected one within 8 cycles");
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
  task automatic req(input logic wr, input logic rd, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] d, input int stall);
    logic flt;
    logic [31:0] w;
    req_valid = 1'b1; MemWrite = wr; MemRead = rd; addrb = a; web = be; dib = d;
    @(posedge clk); #1;
    req_valid = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    track = 1'b1; trk_cyc = 0;
    flt = !in_rng(a);
    m_ready = 1'b0;
    if (wr && !flt) begin
      w = mm.exists(widx(a)) ? mm[widx(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
      mm[widx(a)] = w;
    end
    if (!wr && !flt) begin
      m_valid = 1'b0;
      @(posedge clk); #1;
    end
    m_valid = 1'b1; m_fault = flt;
    if (flt) m_word = '0;
    else if (!wr) m_word = mm[widx(a)];
    rsp_ready = (stall == 0);
    repeat (stall) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0; m_fault = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    addrb = '0; web = '0; dib = '0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_word", DMEM_word, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    // write then immediate read of the same word, unaligned read address
    req(1, 0, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    chk("wr_lat", obs_lat, 1);
    chk("wr_fault", {31'b0, obs_fault}, 0);
    req(0, 1, 32'h13, 4'h0, 32'h0, 0);
    chk("rd_lat", obs_lat, 2);
    chk("rd_word", obs_word, 32'hDEADBEEF);

    // partial byte write merge
    req(1, 0, 32'h20, 4'hF, 32'h11223344, 0);
    req(1, 0, 32'h20, 4'b0100, 32'h00AA0000, 0);
    req(0, 1, 32'h20, 4'h0, 32'h0, 0);
    chk("merge_word", obs_word, 32'h11AA3344);

    // out of range read/write, word 0 untouched
    req(1, 0, 32'h0, 4'hF, 32'hCAFEF00D, 0);
    req(0, 1, 32'h1000, 4'h0, 32'h0, 0);
    chk("oor_rd_lat", obs_lat, 1);
    chk("oor_rd_fault", {31'b0, obs_fault}, 1);
    chk("oor_rd_word", obs_word, 32'h0);
    req(1, 0, 32'h1000, 4'hF, 32'hFFFFFFFF, 0);
    chk("oor_wr_fault", {31'b0, obs_fault}, 1);
    req(0, 1, 32'h0, 4'h0, 32'h0, 0);
    chk("word0_kept", obs_word, 32'hCAFEF00D);

    // last in-range word
    req(1, 0, 32'hFFC, 4'hF, 32'h0BADF00D, 0);
    req(0, 1, 32'hFFC, 4'h0, 32'h0, 0);
    chk("last_word", obs_word, 32'h0BADF00D);
    chk("last_fault", {31'b0, obs_fault}, 0);

    // stalled response
    req(0, 1, 32'h10, 4'h0, 32'h0, 5);
    chk("stall_word", obs_word, 32'hDEADBEEF);

    // web=0 write is acked without change
    req(1, 0, 32'h10, 4'h0, 32'h12345678, 0);
    chk("web0_fault", {31'b0, obs_fault}, 0);
    req(0, 1, 32'h10, 4'h0, 32'h0, 0);
    chk("web0_word", obs_word, 32'hDEADBEEF);

    // request with neither type is ignored; both set acts as write
    req_valid = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; addrb = 32'h30;
    repeat (3) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    req(1, 0, 32'h30, 4'hF, 32'hA0B0C0D0, 0);
    req(1, 1, 32'h30, 4'b0001, 32'h00000055, 0);
    req(0, 1, 32'h30, 4'h0, 32'h0, 0);
    chk("both_word", obs_word, 32'hA0B0C055);

    // small table of mixed writes then readbacks
    for (int i = 0; i < 6; i++)
      req(1, 0, 32'h100 + 32'(4*i), 4'hF, $urandom, 0);
    for (int i = 0; i < 6; i++)
      req(1, 0, 32'h100 + 32'(4*i), 4'($urandom_range(0, 15)), $urandom, 0);
    for (int i = 0; i < 6; i++)
      req(0, 1, 32'h100 + 32'(4*i) + 32'(i % 4), 4'h0, 32'h0, 0);

    // asynchronous reset while in RD
    req_valid = 1'b1; MemRead = 1'b1; addrb = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0; MemRead = 1'b0;
    m_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    m_ready = 1'b1; m_valid = 1'b0; m_word = '0;
    #1;
    chk("rd_rst_valid", {31'b0, rsp_valid}, 0);
    chk("rd_rst_ready", {31'b0, req_ready}, 1);
    chk("rd_rst_word", DMEM_word, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    req(0, 1, 32'h20, 4'h0, 32'h0, 0);
    chk("post_rst_word", obs_word, 32'h11AA3344);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
